// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one-hot row drive, synchronized column sampling, whole-matrix debounce and
// a valid/ready key-code output. Define KEYPAD_REPEAT_EN to add auto-repeat for a held single key.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 1_000_000,
  parameter int unsigned SETTLE    = 16,
  parameter int unsigned DEB_SCANS = 3,
  parameter int unsigned REP_DLY   = 50,
  parameter int unsigned REP_RATE  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row,
  input  logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       multi_key,
  output logic       overrun
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [0:0] {StScan, StEval} state_e;

  state_e            state;
  logic [3:0]        col_meta, col_sync;
  logic [CntW-1:0]   slot_cnt;
  logic [1:0]        row_idx;
  logic [15:0]       snap, prev, deb;
  logic [3:0]        stab_cnt;

  logic [3:0]        stab_nxt;
  logic [15:0]       deb_nxt;
  logic [4:0]        pop_nxt;
  logic [3:0]        code_nxt;
  logic              key_evt;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REP_DLY + REP_RATE + 1);
  logic [RepW-1:0]   rep_cnt, rep_cnt_nxt;
  logic              rep_first, rep_first_nxt, rep_hit;
`else
  // Repeat timing parameters have no effect in this build.
  logic unused_rep_cfg;
  assign unused_rep_cfg = ^{32'(REP_DLY), 32'(REP_RATE)};
`endif

  always_comb begin
    if (snap == prev) begin
      stab_nxt = (stab_cnt >= 4'(DEB_SCANS)) ? 4'(DEB_SCANS) : stab_cnt + 4'd1;
    end else begin
      stab_nxt = 4'd1;
    end
    // prev takes snap on a mismatch, so snap is the accepted state in both cases.
    deb_nxt = (stab_nxt == 4'(DEB_SCANS)) ? snap : deb;

    pop_nxt  = '0;
    code_nxt = '0;
    for (int i = 0; i < 16; i++) begin
      pop_nxt = pop_nxt + 5'(deb_nxt[i]);
      if (deb_nxt[i]) code_nxt = 4'(i);
    end

`ifdef KEYPAD_REPEAT_EN
    rep_hit       = 1'b0;
    rep_cnt_nxt   = '0;
    rep_first_nxt = 1'b0;
    if ((deb_nxt == deb) && (pop_nxt == 5'd1)) begin
      rep_cnt_nxt   = rep_cnt + RepW'(1);
      rep_first_nxt = rep_first;
      if (rep_cnt_nxt == RepW'(rep_first ? REP_RATE : REP_DLY)) begin
        rep_hit       = 1'b1;
        rep_cnt_nxt   = '0;
        rep_first_nxt = 1'b1;
      end
    end
    key_evt = (state == StEval) && (((deb == '0) && (pop_nxt == 5'd1)) || rep_hit);
`else
    key_evt = (state == StEval) && (deb == '0) && (pop_nxt == 5'd1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StScan;
      col_meta  <= '0;
      col_sync  <= '0;
      slot_cnt  <= '0;
      row_idx   <= '0;
      row       <= 4'h1;
      snap      <= '0;
      prev      <= '0;
      deb       <= '0;
      stab_cnt  <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      multi_key <= 1'b0;
      overrun   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b0;
`endif
    end else begin
      col_meta <= key_col;
      col_sync <= col_meta;

      if (slot_cnt == CntW'(SETTLE)) snap[4*row_idx +: 4] <= col_sync;

      if (slot_cnt == CntW'(SCAN_DIV - 1)) begin
        slot_cnt <= '0;
        row_idx  <= row_idx + 2'd1;
        row      <= {row[2:0], row[3]};
      end else begin
        slot_cnt <= slot_cnt + CntW'(1);
      end

      unique case (state)
        StScan: begin
          if ((slot_cnt == CntW'(SCAN_DIV - 1)) && (row_idx == 2'd3)) state <= StEval;
        end
        StEval: begin
          state     <= StScan;
          stab_cnt  <= stab_nxt;
          prev      <= snap;
          deb       <= deb_nxt;
          key_down  <= |deb_nxt;
          multi_key <= (pop_nxt >= 5'd2);
`ifdef KEYPAD_REPEAT_EN
          rep_cnt   <= rep_cnt_nxt;
          rep_first <= rep_first_nxt;
`endif
        end
        default: state <= StScan;
      endcase

      // An accept on the same edge frees the slot for a new code.
      if (key_evt) begin
        if (!key_valid || key_ready) begin
          key_code  <= code_nxt;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a tiny scan period; expected cycles are hand-derived.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_down;
  logic       multi_key;
  logic       overrun;

  logic [15:0] pressed;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          nvalid;
  int          vcyc [8];
  logic [3:0]  vcode [8];

  keypad_scan_ctrl #(
    .SCAN_DIV (8),
    .SETTLE   (2),
    .DEB_SCANS(3),
    .REP_DLY  (4),
    .REP_RATE (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .key_col  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_down (key_down),
    .multi_key(multi_key),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Keypad matrix model: columns of the currently driven row.
  always_comb begin
    key_col = 4'h0;
    case (row)
      4'h1: key_col = pressed[3:0];
      4'h2: key_col = pressed[7:4];
      4'h4: key_col = pressed[11:8];
      4'h8: key_col = pressed[15:12];
      default: key_col = 4'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic watch(input int t);
    nvalid = 0;
    while (cyc < t) begin
      tick();
      if (key_valid === 1'b1) begin
        if (nvalid < 8) begin
          vcyc[nvalid]  = cyc;
          vcode[nvalid] = key_code;
        end
        nvalid++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    pressed   = 16'h0;
    key_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b1;
    pressed   = 16'h0;
    key_ready = 1'b1;
    #2;

    // Reset state
    do_reset();
    check("rst_row", row, 4'h1);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_down", key_down, 1'b0);
    check("rst_multi", multi_key, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // 1: hold row2/col1 (code 9)
    pressed = 16'h0200;
    run_to(8);   check("t1_row_8", row, 4'h2);
    run_to(16);  check("t1_row_16", row, 4'h4);
    run_to(24);  check("t1_row_24", row, 4'h8);
    run_to(32);  check("t1_row_32", row, 4'h1);
    run_to(96);  check("t1_valid_early", key_valid, 1'b0);
    run_to(97);
    check("t1_valid", key_valid, 1'b1);
    check("t1_code", key_code, 4'h9);
    check("t1_down", key_down, 1'b1);
    check("t1_multi", multi_key, 1'b0);
    run_to(98);  check("t1_valid_drop", key_valid, 1'b0);
    watch(250);  check("t1_no_second", nvalid, 0);

    // 2: bounce key 0 for two scans, then hold
    do_reset();
    for (int c = 0; c < 64; c++) begin
      pressed = (((c / 5) % 2) == 1) ? 16'h0001 : 16'h0000;
      tick();
    end
    pressed = 16'h0001;
    watch(300);
    check("t2_count", nvalid, 1);
    check("t2_cycle", vcyc[0], 161);
    check("t2_code", vcode[0], 4'h0);

    // 3: consumer stalled, second press overruns
    do_reset();
    key_ready = 1'b0;
    pressed   = 16'h0020;
    run_to(97);
    check("t3_valid", key_valid, 1'b1);
    check("t3_code", key_code, 4'h5);
    run_to(100); pressed = 16'h0000;
    run_to(200); pressed = 16'h0400;
    run_to(288);
    check("t3_ovr_before", overrun, 1'b0);
    run_to(289);
    check("t3_ovr", overrun, 1'b1);
    check("t3_valid_held", key_valid, 1'b1);
    check("t3_code_held", key_code, 4'h5);
    run_to(295);
    check("t3_valid_stall", key_valid, 1'b1);
    key_ready = 1'b1;
    run_to(296);
    check("t3_valid_drop", key_valid, 1'b0);
    check("t3_ovr_sticky", overrun, 1'b1);

    // 4: two keys together
    do_reset();
    pressed = 16'h1008;
    watch(128);
    check("t4_no_code", nvalid, 0);
    check("t4_down", key_down, 1'b1);
    check("t4_multi", multi_key, 1'b1);
    pressed = 16'h0000;
    watch(224);
    check("t4_no_code_rel", nvalid, 0);
    check("t4_multi_hold", multi_key, 1'b1);
    run_to(225);
    check("t4_down_rel", key_down, 1'b0);
    check("t4_multi_rel", multi_key, 1'b0);

    // 5: asynchronous reset mid-scan with a pending code
    do_reset();
    key_ready = 1'b0;
    pressed   = 16'h0200;
    run_to(110);
    check("t5_valid_pre", key_valid, 1'b1);
    check("t5_row_pre", row, 4'h2);
    rst_n = 1'b0;
    #1;
    check("t5_row", row, 4'h1);
    check("t5_valid", key_valid, 1'b0);
    check("t5_code", key_code, 4'h0);
    check("t5_down", key_down, 1'b0);
    check("t5_multi", multi_key, 1'b0);
    check("t5_overrun", overrun, 1'b0);

    // 6: hold key 7 with the consumer always ready
    do_reset();
    pressed = 16'h0080;
    watch(370);
`ifdef KEYPAD_REPEAT_EN
    check("t6_count", nvalid, 4);
    check("t6_cyc0", vcyc[0], 97);
    check("t6_cyc1", vcyc[1], 225);
    check("t6_cyc2", vcyc[2], 289);
    check("t6_cyc3", vcyc[3], 353);
    check("t6_code3", vcode[3], 4'h7);
`else
    check("t6_count", nvalid, 1);
    check("t6_cyc0", vcyc[0], 97);
`endif
    check("t6_code0", vcode[0], 4'h7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
